// File: rtl/layer_sequencer.sv
// Host-side layer command sequencer for the MNIST accelerator: walks a per-layer
// config table, issues one go per layer, waits for done, and serves image bytes.
module layer_sequencer #(
  parameter int MAX_LAYERS = 7,
  parameter int IMG_DEPTH  = 784,
  parameter int IMG_AW     = 10,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 1000000
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [2:0]            num_layers,
  input  logic                  cfg_we,
  input  logic [2:0]            cfg_layer,
  input  logic [2:0]            cfg_field,
  input  logic [31:0]           cfg_wdata,
  input  logic                  img_we,
  input  logic [IMG_AW-1:0]     img_waddr,
  input  logic [DATA_WIDTH-1:0] img_wdata,
  output logic                  busy,
  output logic                  finished,
  output logic                  error,
  output logic [31:0]           total_cycles,
  output logic                  go,
  output logic [2:0]            layer_index,
  output logic [31:0]           data_address,
  output logic [31:0]           data_size,
  output logic [31:0]           weight_address,
  output logic [31:0]           weight_size,
  output logic [31:0]           result_address,
  input  logic [2:0]            done,
  input  logic [31:0]           image_idx,
  output logic [DATA_WIDTH-1:0] image
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, GAP, FINISH, ERROR} state_t;

  typedef struct packed {
    logic [31:0] data_address;
    logic [31:0] data_size;
    logic [31:0] weight_address;
    logic [31:0] weight_size;
    logic [31:0] result_address;
  } cfg_t;

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  state_t                state;
  cfg_t                  tbl [MAX_LAYERS];
  logic [DATA_WIDTH-1:0] img_mem [IMG_DEPTH];
  logic [TW-1:0]         tcnt;
  logic [2:0]            nl_q;
  logic [2:0]            nl_clamp;
  logic [3:0]            next_layer;

  always_comb begin
    nl_clamp   = (int'(num_layers) > MAX_LAYERS) ? 3'(MAX_LAYERS) : num_layers;
    next_layer = {1'b0, layer_index} + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state          <= IDLE;
      go             <= 1'b0;
      busy           <= 1'b0;
      finished       <= 1'b0;
      error          <= 1'b0;
      layer_index    <= '0;
      data_address   <= '0;
      data_size      <= '0;
      weight_address <= '0;
      weight_size    <= '0;
      result_address <= '0;
      total_cycles   <= '0;
      tcnt           <= '0;
      nl_q           <= '0;
    end else begin
      finished <= 1'b0;
      if (state inside {ISSUE, WAIT, GAP}) total_cycles <= total_cycles + 32'd1;
      case (state)
        IDLE: if (start) begin
          error        <= 1'b0;
          total_cycles <= '0;
          layer_index  <= '0;
          if (num_layers == 3'd0) begin
            state <= FINISH;
          end else begin
            nl_q  <= nl_clamp;
            busy  <= 1'b1;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          // table read happens here, so a write landing alongside start is seen
          data_address   <= tbl[layer_index].data_address;
          data_size      <= tbl[layer_index].data_size;
          weight_address <= tbl[layer_index].weight_address;
          weight_size    <= tbl[layer_index].weight_size;
          result_address <= tbl[layer_index].result_address;
          go             <= 1'b1;
          tcnt           <= '0;
          state          <= WAIT;
        end
        WAIT: begin
          if (done == layer_index + 3'd1) begin
            go    <= 1'b0;
            state <= GAP;
          end else if (tcnt == TW'(TIMEOUT - 1)) begin
            go    <= 1'b0;
            error <= 1'b1;
            busy  <= 1'b0;
            state <= ERROR;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        GAP: begin
          if (next_layer < {1'b0, nl_q}) begin
            layer_index <= layer_index + 3'd1;
            state       <= ISSUE;
          end else begin
            busy  <= 1'b0;
            state <= FINISH;
          end
        end
        FINISH: begin
          finished <= 1'b1;
          state    <= IDLE;
        end
        ERROR:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Storage is never reset; writes only while idle.
  always_ff @(posedge clk) begin
    if (cfg_we && state == IDLE && int'(cfg_layer) < MAX_LAYERS) begin
      case (cfg_field)
        3'd0:    tbl[cfg_layer].data_address   <= cfg_wdata;
        3'd1:    tbl[cfg_layer].data_size      <= cfg_wdata;
        3'd2:    tbl[cfg_layer].weight_address <= cfg_wdata;
        3'd3:    tbl[cfg_layer].weight_size    <= cfg_wdata;
        3'd4:    tbl[cfg_layer].result_address <= cfg_wdata;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (img_we && state == IDLE && int'(img_waddr) < IMG_DEPTH)
      img_mem[img_waddr] <= img_wdata;
    image <= (image_idx < 32'(IMG_DEPTH)) ? img_mem[image_idx[IMG_AW-1:0]] : '0;
  end

endmodule

// File: tb/tb_layer_sequencer.sv
// Bench for layer_sequencer: accelerator model on go, scoreboard of expected
// per-layer commands, image read vector table and multi-cycle corner sequences.
module tb_layer_sequencer;
  localparam int ML = 7, DEPTH = 784, AW = 10, DW = 8, TO = 16;

  logic          clk = 1'b0, rstn = 1'b0, start = 1'b0;
  logic [2:0]    num_layers = '0;
  logic          cfg_we = 1'b0;
  logic [2:0]    cfg_layer = '0, cfg_field = '0;
  logic [31:0]   cfg_wdata = '0;
  logic          img_we = 1'b0;
  logic [AW-1:0] img_waddr = '0;
  logic [DW-1:0] img_wdata = '0;
  logic          busy, finished, error, go;
  logic [31:0]   total_cycles;
  logic [2:0]    layer_index;
  logic [31:0]   data_address, data_size, weight_address, weight_size, result_address;
  logic [2:0]    done = '0;
  logic [31:0]   image_idx = '0;
  logic [DW-1:0] image;

  always #5 clk = ~clk;

  layer_sequencer #(.MAX_LAYERS(ML), .IMG_DEPTH(DEPTH), .IMG_AW(AW),
                    .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rstn(rstn), .start(start), .num_layers(num_layers),
    .cfg_we(cfg_we), .cfg_layer(cfg_layer), .cfg_field(cfg_field), .cfg_wdata(cfg_wdata),
    .img_we(img_we), .img_waddr(img_waddr), .img_wdata(img_wdata),
    .busy(busy), .finished(finished), .error(error), .total_cycles(total_cycles),
    .go(go), .layer_index(layer_index), .data_address(data_address), .data_size(data_size),
    .weight_address(weight_address), .weight_size(weight_size), .result_address(result_address),
    .done(done), .image_idx(image_idx), .image(image));

  typedef struct packed {
    logic [2:0]       li;
    logic [4:0][31:0] f;
  } sb_t;

  typedef struct {
    logic [31:0] idx;
    logic [7:0]  exp;
  } ivec_t;

  int total = 0, bad = 0;
  sb_t sb[$];
  logic [4:0][31:0] exp_tbl [ML];
  bit model_en = 1'b0;
  int rise_cnt = 0, fin_cnt = 0, rises_run = 0, high_len = 0, low_len = 0, last_high = 0;
  logic go_d = 1'b0, fin_d = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_wr(input int l, input int f, input logic [31:0] d, input bit lands);
    cfg_we = 1'b1; cfg_layer = 3'(l); cfg_field = 3'(f); cfg_wdata = d;
    if (lands) exp_tbl[l][f] = d;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic push_run(input int n);
    sb_t e;
    rises_run = 0;
    for (int i = 0; i < n; i++) begin
      e.li = 3'(i);
      e.f  = exp_tbl[i];
      sb.push_back(e);
    end
  endtask

  task automatic start_pulse(input int n);
    start = 1'b1; num_layers = 3'(n);
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int k = 0;
    while (busy && k < 200) begin step(); k++; end
    chk({nm, "_busy_bound"}, 64'(busy), 64'd0);
    step();
    step();
  endtask

  // Accelerator model and command monitor, sampled on the inactive edge.
  initial forever begin
    sb_t e;
    @(negedge clk);
    if (finished) begin
      chk("finished_width", 64'(fin_d), 64'd0);
      fin_cnt++;
    end
    if (go && !go_d) begin
      rise_cnt++;
      if (rises_run > 0) chk("go_low_gap", 64'(low_len >= 1), 64'd1);
      rises_run++;
      high_len = 0;
      if (sb.size() == 0) chk("sb_underflow", 64'd1, 64'd0);
      else begin
        e = sb.pop_front();
        chk("layer_index",    64'(layer_index),    64'(e.li));
        chk("data_address",   64'(data_address),   64'(e.f[0]));
        chk("data_size",      64'(data_size),      64'(e.f[1]));
        chk("weight_address", 64'(weight_address), 64'(e.f[2]));
        chk("weight_size",    64'(weight_size),    64'(e.f[3]));
        chk("result_address", 64'(result_address), 64'(e.f[4]));
      end
    end
    if (go) begin
      high_len++;
      if (model_en && high_len == 5) done = layer_index + 3'd1;
    end else begin
      if (go_d) begin last_high = high_len; low_len = 0; end
      low_len++;
      done = '0;
    end
    go_d  = go;
    fin_d = finished;
  end

  initial begin
    ivec_t iv[6];
    int r0, f0, k;
    iv[0] = '{32'd0,          8'h00};
    iv[1] = '{32'd783,        8'h0F};
    iv[2] = '{32'd784,        8'h00};
    iv[3] = '{32'hFFFF_FFFF,  8'h00};
    iv[4] = '{32'd300,        8'h2C};
    iv[5] = '{32'd10,         8'h0A};

    rstn = 1'b0;
    step(); step();
    chk("rst_go",       64'(go), 0);
    chk("rst_busy",     64'(busy), 0);
    chk("rst_finished", 64'(finished), 0);
    chk("rst_error",    64'(error), 0);
    chk("rst_layer",    64'(layer_index), 0);
    chk("rst_daddr",    64'(data_address), 0);
    chk("rst_wsize",    64'(weight_size), 0);
    chk("rst_raddr",    64'(result_address), 0);
    chk("rst_cycles",   64'(total_cycles), 0);
    rstn = 1'b1;
    step();

    for (int l = 0; l < ML; l++)
      for (int f = 0; f < 5; f++)
        cfg_wr(l, f, 32'(32'h1000 * (l + 1) + f * 4 + 32'hA000_0000), 1'b1);
    cfg_wr(1, 0, 32'h100, 1'b1);
    cfg_wr(1, 3, 32'h40, 1'b1);

    for (int i = 0; i < DEPTH; i++) begin
      img_we = 1'b1; img_waddr = AW'(i); img_wdata = 8'(i);
      step();
    end
    img_we = 1'b0;

    for (int i = 0; i < 6; i++) begin
      image_idx = iv[i].idx;
      step();
      chk("image_read", 64'(image), 64'(iv[i].exp));
    end

    // three-layer run
    model_en = 1'b1;
    r0 = rise_cnt; f0 = fin_cnt;
    push_run(3);
    start_pulse(3);
    wait_done("run3");
    chk("run3_go_count", 64'(rise_cnt - r0), 3);
    chk("run3_finished", 64'(fin_cnt - f0), 1);
    chk("run3_busy",     64'(busy), 0);
    chk("run3_error",    64'(error), 0);
    chk("run3_cycles",   64'(total_cycles), 21);
    chk("run3_sb_empty", 64'(sb.size()), 0);

    // timeout: accelerator silent
    model_en = 1'b0;
    r0 = rise_cnt; f0 = fin_cnt;
    push_run(1);
    start_pulse(1);
    wait_done("tmo");
    chk("tmo_error",     64'(error), 1);
    chk("tmo_go_len",    64'(last_high), 16);
    chk("tmo_finished",  64'(fin_cnt - f0), 0);
    chk("tmo_go",        64'(go), 0);
    chk("tmo_cycles",    64'(total_cycles), 17);

    // next start clears error
    model_en = 1'b1;
    f0 = fin_cnt;
    push_run(1);
    start_pulse(1);
    chk("err_cleared", 64'(error), 0);
    wait_done("clr");
    chk("clr_finished", 64'(fin_cnt - f0), 1);
    chk("clr_error",    64'(error), 0);

    // zero layers: finished two cycles after start, no go
    r0 = rise_cnt; f0 = fin_cnt;
    start = 1'b1; num_layers = 3'd0;
    step();
    start = 1'b0;
    chk("nl0_fin_t1", 64'(finished), 0);
    step();
    chk("nl0_fin_t2", 64'(finished), 1);
    chk("nl0_busy",   64'(busy), 0);
    step();
    chk("nl0_fin_t3", 64'(finished), 0);
    chk("nl0_no_go",  64'(rise_cnt - r0), 0);

    // reset during layer 1 wait
    push_run(3);
    start_pulse(3);
    k = 0;
    while (!(go && layer_index == 3'd1) && k < 100) begin step(); k++; end
    chk("mid_reach_layer1", 64'(go && layer_index == 3'd1), 1);
    step();
    f0 = fin_cnt;
    rstn = 1'b0;
    step();
    chk("mid_rst_go",    64'(go), 0);
    chk("mid_rst_busy",  64'(busy), 0);
    chk("mid_rst_layer", 64'(layer_index), 0);
    rstn = 1'b1;
    sb.delete();
    step(); step();
    chk("mid_rst_no_fin", 64'(fin_cnt - f0), 0);
    f0 = fin_cnt;
    push_run(3);
    start_pulse(3);
    wait_done("rerun");
    chk("rerun_finished", 64'(fin_cnt - f0), 1);
    chk("rerun_sb_empty", 64'(sb.size()), 0);

    // writes and start while busy are ignored
    r0 = rise_cnt; f0 = fin_cnt;
    push_run(2);
    start_pulse(2);
    k = 0;
    while (!go && k < 20) begin step(); k++; end
    cfg_wr(0, 0, 32'hDEAD_BEEF, 1'b0);
    img_we = 1'b1; img_waddr = AW'(10); img_wdata = 8'hEE;
    step();
    img_we = 1'b0;
    start = 1'b1; num_layers = 3'd5;
    step();
    start = 1'b0;
    wait_done("busyw");
    chk("busyw_go_count", 64'(rise_cnt - r0), 2);
    chk("busyw_finished", 64'(fin_cnt - f0), 1);
    image_idx = 32'd10;
    step();
    chk("busyw_image", 64'(image), 64'h0A);

    // config write coincident with start is used by the run
    f0 = fin_cnt;
    exp_tbl[0][4] = 32'h5555_0000;
    push_run(1);
    cfg_we = 1'b1; cfg_layer = 3'd0; cfg_field = 3'd4; cfg_wdata = 32'h5555_0000;
    start = 1'b1; num_layers = 3'd1;
    step();
    cfg_we = 1'b0; start = 1'b0;
    wait_done("cfgst");
    chk("cfgst_finished", 64'(fin_cnt - f0), 1);
    chk("cfgst_sb_empty", 64'(sb.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_time_limit actual=expired required=finish");
    $fatal(1, "time limit");
  end
endmodule
